// File: rtl/decimal_key_scheduler_pkg.sv
// Shared constants, types and arbitration helpers for the decimal key scheduler.
package decimal_sched_pkg;

  localparam int unsigned NUM_DIGITS = 10;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned PTR_W      = 4;

  typedef logic [NUM_DIGITS-1:0] key_vec_t;
  typedef logic [BCD_W-1:0]      bcd_t;
  typedef logic [PTR_W-1:0]      rr_ptr_t;

  // Advance a round-robin index, wrapping 9 -> 0.
  function automatic rr_ptr_t ptr_inc(input rr_ptr_t p);
    return (p == PTR_W'(NUM_DIGITS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // First set request at or after ptr (wrapping), returned as a one-hot vector.
  function automatic key_vec_t rr_pick(input key_vec_t req, input rr_ptr_t ptr);
    key_vec_t gnt;
    rr_ptr_t  idx;
    logic     found;
    gnt   = '0;
    idx   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
      idx = ptr_inc(idx);
    end
    return gnt;
  endfunction

endpackage

// File: rtl/decimal_key_scheduler_if.sv
// Digit stream between the scheduler FIFO and its consumer.
interface decimal_key_scheduler_if;
  import decimal_sched_pkg::*;

  bcd_t digit_out;
  logic digit_valid;
  logic digit_ready;

  modport master (output digit_out, output digit_valid, input digit_ready);
  modport slave  (input digit_out, input digit_valid, output digit_ready);
endinterface

// File: rtl/decimal_key_scheduler_enc.sv
// Combinational 10-bit one-hot to BCD encoder; all-zero input gives 0.
module onehot10_bcd_enc
  import decimal_sched_pkg::*;
(
  input  key_vec_t onehot,
  output bcd_t     bcd_c
);

  // OR-reduce the index of the set bit; input is one-hot or zero.
  always_comb begin
    bcd_c = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (onehot[i]) begin
        bcd_c = bcd_c | BCD_W'(i);
      end
    end
  end

endmodule

// File: rtl/decimal_key_scheduler.sv
// Serialises ten decimal key lines into a round-robin ordered BCD digit stream.
module decimal_key_scheduler
  import decimal_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
)
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  key_vec_t                     key_in,
  input  logic                         clear_ovf,
  decimal_key_scheduler_if.master      dig,
  output key_vec_t                     pending,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned AW    = $clog2(DEPTH);

  key_vec_t          sync1;
  key_vec_t          sync_s;
  key_vec_t          prev;
  rr_ptr_t           ptr;
  bcd_t              mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;

  key_vec_t          rise_c;
  key_vec_t          grant_c;
  key_vec_t          pending_next_c;
  logic              pop_c;
  logic              push_c;
  logic              push_ok_c;
  logic              ovf_set_c;
  bcd_t              enc_c;
  bcd_t              head_next_c;
  logic [AW-1:0]     rd_ptr_next_c;
  logic [AW-1:0]     wr_ptr_next_c;
  logic [CNT_W-1:0]  count_next_c;

  onehot10_bcd_enc u_enc (
    .onehot (grant_c),
    .bcd_c  (enc_c)
  );

  // Edge detect, arbitration gated on FIFO space, pending and overflow next-state.
  always_comb begin
    rise_c         = sync_s & ~prev;
    pop_c          = dig.digit_valid && dig.digit_ready;
    push_ok_c      = (fifo_count < CNT_W'(DEPTH)) || pop_c;
    grant_c        = push_ok_c ? rr_pick(pending, ptr) : '0;
    push_c         = |grant_c;
    pending_next_c = (pending & ~grant_c) | rise_c;
    ovf_set_c      = |(rise_c & pending & ~grant_c);
  end

  // FIFO pointer/count next-state and the head value to present after this edge.
  always_comb begin
    rd_ptr_next_c = pop_c  ? rd_ptr + AW'(1) : rd_ptr;
    wr_ptr_next_c = push_c ? wr_ptr + AW'(1) : wr_ptr;
    count_next_c  = fifo_count;
    if (push_c && !pop_c) begin
      count_next_c = fifo_count + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_next_c = fifo_count - CNT_W'(1);
    end
    head_next_c = '0;
    if (count_next_c != '0) begin
      // The head slot is being written this cycle only when the FIFO drains to it.
      if (push_c && (rd_ptr_next_c == wr_ptr)) begin
        head_next_c = enc_c;
      end else begin
        head_next_c = mem[rd_ptr_next_c];
      end
    end
  end

  // Key synchroniser, previous level, pending set, RR pointer and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync_s   <= '0;
      prev     <= '0;
      pending  <= '0;
      ptr      <= '0;
      overflow <= 1'b0;
    end else begin
      sync1   <= key_in;
      sync_s  <= sync1;
      prev    <= sync_s;
      pending <= pending_next_c;
      if (push_c) begin
        ptr <= ptr_inc(rr_ptr_t'(enc_c));
      end
      if (ovf_set_c) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= enc_c;
      end
      rd_ptr     <= rd_ptr_next_c;
      wr_ptr     <= wr_ptr_next_c;
      fifo_count <= count_next_c;
    end
  end

  // Registered first-word-fall-through head and valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig.digit_out   <= '0;
      dig.digit_valid <= 1'b0;
    end else begin
      dig.digit_out   <= head_next_c;
      dig.digit_valid <= (count_next_c != '0);
    end
  end

endmodule

// File: tb/tb_decimal_key_scheduler.sv
// Scoreboard bench for decimal_key_scheduler: cycle model of the key/arbiter rules,
// expected digits queued at grant time and consumed by a separate monitor.
module tb_decimal_key_scheduler;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [9:0]       key_in = '0;
  logic             clear_ovf = 1'b0;
  logic [9:0]       pending;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;

  decimal_key_scheduler_if dig_if ();

  decimal_key_scheduler #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .clear_ovf  (clear_ovf),
    .dig        (dig_if),
    .pending    (pending),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Reference model state: key history, pending set, RR index, occupancy, overflow.
  logic [9:0] m_k1 = '0, m_k2 = '0, m_k3 = '0, m_pend = '0;
  int         m_ptr = 0;
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;
  int         exp_q[$];
  int         flush_idx = 0;

  // Model advances on the same edge as the DUT; inputs are stable around it.
  always @(posedge clk or negedge rst_n) begin : model_b
    logic [9:0] rise, gmask;
    bit         pop;
    int         g;
    if (!rst_n) begin
      m_k1 = '0; m_k2 = '0; m_k3 = '0; m_pend = '0;
      m_ptr = 0; m_cnt = 0; m_ovf = 1'b0;
      flush_idx = exp_q.size();
    end else begin
      rise = m_k2 & ~m_k3;
      pop  = (m_cnt > 0) && dig_if.digit_ready;
      g    = -1;
      if (m_cnt < int'(DEPTH) || pop) begin
        for (int k = 0; k < 10; k++) begin
          if (g < 0 && m_pend[(m_ptr + k) % 10]) g = (m_ptr + k) % 10;
        end
      end
      gmask = (g >= 0) ? (10'(1) << g) : '0;
      if (g >= 0) begin
        exp_q.push_back(g);
        m_ptr = (g + 1) % 10;
      end
      if ((rise & m_pend & ~gmask) != '0) m_ovf = 1'b1;
      else if (clear_ovf)                  m_ovf = 1'b0;
      m_pend = (m_pend & ~gmask) | rise;
      m_cnt  = m_cnt + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
      m_k3 = m_k2;
      m_k2 = m_k1;
      m_k1 = key_in;
    end
  end

  int total = 0;
  int bad = 0;
  int rd_idx = 0;
  bit end_chk = 1'b0;
  bit end_seen = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares outputs away from the active edge and consumes expected digits.
  always @(negedge clk or negedge rst_n) begin : mon_b
    int e_dig;
    if (!rst_n) begin
      #1;
      chk("rst_digit_out",   int'(dig_if.digit_out), 0);
      chk("rst_digit_valid", int'(dig_if.digit_valid), 0);
      chk("rst_pending",     int'(pending), 0);
      chk("rst_fifo_count",  int'(fifo_count), 0);
      chk("rst_overflow",    int'(overflow), 0);
      rd_idx = flush_idx;
    end else begin
      e_dig = (rd_idx < exp_q.size()) ? exp_q[rd_idx] : 0;
      chk("digit_out",   int'(dig_if.digit_out), e_dig);
      chk("digit_valid", int'(dig_if.digit_valid), (m_cnt > 0) ? 1 : 0);
      chk("fifo_count",  int'(fifo_count), m_cnt);
      chk("pending",     int'(pending), int'(m_pend));
      chk("overflow",    int'(overflow), int'(m_ovf));
      if (dig_if.digit_valid && dig_if.digit_ready && rd_idx < exp_q.size()) rd_idx++;
      if (end_chk && !end_seen) begin
        end_seen = 1'b1;
        chk("undelivered_digits", exp_q.size() - rd_idx, 0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press a key set, hold two cycles, release, then let things settle.
  task automatic tap(input logic [9:0] m, input int settle);
    key_in = m;
    step(2);
    key_in = '0;
    step(settle);
  endtask

  initial begin
    dig_if.digit_ready = 1'b0;
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    dig_if.digit_ready = 1'b1;
    step(2);

    // Single press of key 7.
    tap(10'h080, 8);
    // Keys 2, 5, 9 together.
    tap(10'h224, 10);
    // Grant 5 to move the pointer, then keys 1 and 8 together.
    tap(10'h020, 6);
    tap(10'h102, 8);

    // Back-pressure: six presses into a 4-deep FIFO, then drain.
    dig_if.digit_ready = 1'b0;
    tap(10'h15D, 10);
    dig_if.digit_ready = 1'b1;
    step(12);

    // Overflow: FIFO full, key 3 pending, key 3 released and re-pressed.
    dig_if.digit_ready = 1'b0;
    tap(10'h017, 8);
    key_in = 10'h008;
    step(4);
    key_in = '0;
    step(2);
    key_in = 10'h008;
    step(4);
    key_in = '0;
    step(2);
    clear_ovf = 1'b1;
    step(1);
    clear_ovf = 1'b0;
    dig_if.digit_ready = 1'b1;
    step(10);

    // Reset with three buffered digits and two pending presses.
    dig_if.digit_ready = 1'b0;
    key_in = 10'h0C7;
    step(6);
    #2 rst_n = 1'b0;
    key_in = '0;
    step(3);
    rst_n = 1'b1;
    dig_if.digit_ready = 1'b1;
    step(10);

    // Randomised key toggling, ready and overflow clears.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) key_in = key_in ^ (10'(1) << $urandom_range(0, 9));
      dig_if.digit_ready = ($urandom_range(0, 99) < 65);
      clear_ovf = ($urandom_range(0, 15) == 0);
      step(1);
    end

    key_in = '0;
    clear_ovf = 1'b0;
    dig_if.digit_ready = 1'b1;
    step(30);
    end_chk = 1'b1;
    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
